// File: rtl/pipeline_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_pkg
// Shared constants for the five-stage pipeline registers.
//   - Default payload widths for the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
//   - MEM/WB field offsets and widths, plus a packed struct view of that payload.
//   - Stage operation codes used by pipe_reg_chain to drive every pipe_stage.
//   - Small helpers to pack and unpack a MEM/WB payload.
// ---------------------------------------------------------------------------
package pipeline_pkg;

    // Default payload widths for each inter-stage register.
    // IF/ID  : PC+4 (32) + instruction (32)
    // ID/EX  : control (9) + PC+4 (32) + rs data (32) + rt data (32)
    //          + sign-extended immediate (32) + rt (5) + rd (5)
    // EX/MEM : control (5) + branch target (32) + zero flag (1)
    //          + ALU result (32) + rt data (32) + write register (5)
    // MEM/WB : MemtoReg (1) + RegWrite (1) + memory read data (32)
    //          + ALU result (32) + write register (5)
    localparam int IF_ID_W  = 64;
    localparam int ID_EX_W  = 147;
    localparam int EX_MEM_W = 107;
    localparam int MEM_WB_W = 71;

    // MEM/WB field widths.
    localparam int MEM_WB_WRITEREG_W    = 5;
    localparam int MEM_WB_ALURESULT_W   = 32;
    localparam int MEM_WB_MEMREADDATA_W = 32;

    // MEM/WB field offsets (LSB position of each field).
    localparam int MEM_WB_WRITEREG_LSB    = 0;
    localparam int MEM_WB_ALURESULT_LSB   = MEM_WB_WRITEREG_LSB + MEM_WB_WRITEREG_W;
    localparam int MEM_WB_MEMREADDATA_LSB = MEM_WB_ALURESULT_LSB + MEM_WB_ALURESULT_W;
    localparam int MEM_WB_REGWRITE_BIT    = MEM_WB_MEMREADDATA_LSB + MEM_WB_MEMREADDATA_W;
    localparam int MEM_WB_MEMTOREG_BIT    = MEM_WB_REGWRITE_BIT + 1;

    // Struct view of the MEM/WB payload; member order matches the offsets above
    // (first member is the MSB).
    typedef struct packed {
        logic        memtoReg;
        logic        regWrite;
        logic [31:0] memReadData;
        logic [31:0] aluResult;
        logic [4:0]  writeReg;
    } mem_wb_t;

    // Stage operation selected once per cycle for the whole chain.
    // Flush outranks stall, stall outranks advance.
    localparam logic [1:0] STAGE_ADVANCE = 2'd0;
    localparam logic [1:0] STAGE_HOLD    = 2'd1;
    localparam logic [1:0] STAGE_FLUSH   = 2'd2;

    // Build a flat MEM/WB payload from its fields.
    function automatic logic [MEM_WB_W-1:0] pack_mem_wb(
        input logic        memtoReg,
        input logic        regWrite,
        input logic [31:0] memReadData,
        input logic [31:0] aluResult,
        input logic [4:0]  writeReg
    );
        mem_wb_t fields;
        fields.memtoReg    = memtoReg;
        fields.regWrite    = regWrite;
        fields.memReadData = memReadData;
        fields.aluResult   = aluResult;
        fields.writeReg    = writeReg;
        return fields;
    endfunction

    // Reinterpret a flat MEM/WB payload as its struct view.
    function automatic mem_wb_t unpack_mem_wb(input logic [MEM_WB_W-1:0] payload);
        return mem_wb_t'(payload);
    endfunction

endpackage

// File: rtl/pipe_reg_chain_stage.sv
// ---------------------------------------------------------------------------
// pipe_stage
// One pipeline register: a valid bit plus a WIDTH-bit payload.
// Ports:
//   clk_i    rising-edge clock
//   rst_i    asynchronous active-high reset, clears valid and payload
//   op_i     STAGE_ADVANCE / STAGE_HOLD / STAGE_FLUSH (from pipeline_pkg)
//   valid_i  valid bit from the previous stage (or upstream)
//   data_i   payload from the previous stage (or upstream)
//   valid_o  registered valid bit
//   data_o   registered payload
// ZERO_BUBBLE selects whether a flush also clears the payload (1) or only
// the valid bit (0).
// ---------------------------------------------------------------------------
module pipe_stage
    import pipeline_pkg::*;
#(
    parameter int WIDTH       = 71,
    parameter int ZERO_BUBBLE = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [1:0]       op_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q;
    logic             valid_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Next-state selection. Holding is the default so that any unexpected
    // op code freezes the stage rather than corrupting it. A bubble on the
    // advance path still captures its payload as-is; only flush may zero it.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        case (op_i)
            STAGE_ADVANCE: begin
                valid_d = valid_i;
                data_d  = data_i;
            end
            STAGE_FLUSH: begin
                valid_d = 1'b0;
                if (ZERO_BUBBLE != 0) begin
                    data_d = '0;
                end
            end
            default: begin
                valid_d = valid_q;
                data_d  = data_q;
            end
        endcase
    end

    // Stage registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_reg_chain.sv
// ---------------------------------------------------------------------------
// pipe_reg_chain
// A DEPTH-deep chain of pipeline registers with a common stall and flush,
// an occupancy count and a saturating stall-cycle counter.
// Ports:
//   Clk          rising-edge clock
//   Rst          asynchronous active-high reset
//   InValid      upstream stage holds a real instruction
//   InData       upstream payload (WIDTH bits)
//   Stall        freeze the whole chain this cycle (input is dropped)
//   Flush        invalidate every stage this cycle (wins over Stall)
//   OutValid     last stage holds a real instruction
//   OutData      raw last-stage payload, qualify with OutValid
//   Occupancy    number of valid stages, 0..DEPTH
//   StallCycles  saturating count of cycles with Stall=1 and Flush=0
// All outputs come straight from flops; nothing passes combinationally from
// an input to an output. With DEPTH=1, ZERO_BUBBLE=0 and WIDTH=71 this is the
// MEM/WB register.
// ---------------------------------------------------------------------------
module pipe_reg_chain
    import pipeline_pkg::*;
#(
    parameter int WIDTH       = MEM_WB_W,
    parameter int DEPTH       = 1,
    parameter int ZERO_BUBBLE = 1,
    parameter int CNT_W       = 16
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic                       InValid,
    input  logic [WIDTH-1:0]           InData,
    input  logic                       Stall,
    input  logic                       Flush,
    output logic                       OutValid,
    output logic [WIDTH-1:0]           OutData,
    output logic [$clog2(DEPTH+1)-1:0] Occupancy,
    output logic [CNT_W-1:0]           StallCycles
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [1:0]             stageOp;
    logic [DEPTH-1:0]       stageValidIn;
    logic [DEPTH*WIDTH-1:0] stageDataIn;
    logic [DEPTH-1:0]       stageValid;
    logic [DEPTH*WIDTH-1:0] stageData;

    logic [DEPTH-1:0]       nextValid;
    logic [OCC_W-1:0]       occ_q;
    logic [OCC_W-1:0]       occ_d;
    logic [CNT_W-1:0]       stallCnt_q;
    logic [CNT_W-1:0]       stallCnt_d;

    // One operation for the whole chain, resolved in priority order
    // flush > stall > advance. Reset is handled by the flops themselves.
    always_comb begin
        stageOp = STAGE_ADVANCE;
        if (Flush) begin
            stageOp = STAGE_FLUSH;
        end else if (Stall) begin
            stageOp = STAGE_HOLD;
        end
    end

    // Stage 0 is fed from the upstream inputs, every later stage from its
    // predecessor. The k==0 split keeps the k-1 index out of stage 0.
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign stageValidIn[k]                = InValid;
            assign stageDataIn[k*WIDTH +: WIDTH]  = InData;
        end else begin : g_body
            assign stageValidIn[k]                = stageValid[k-1];
            assign stageDataIn[k*WIDTH +: WIDTH]  = stageData[(k-1)*WIDTH +: WIDTH];
        end

        pipe_stage #(
            .WIDTH       (WIDTH),
            .ZERO_BUBBLE (ZERO_BUBBLE)
        ) u_stage (
            .clk_i   (Clk),
            .rst_i   (Rst),
            .op_i    (stageOp),
            .valid_i (stageValidIn[k]),
            .data_i  (stageDataIn[k*WIDTH +: WIDTH]),
            .valid_o (stageValid[k]),
            .data_o  (stageData[k*WIDTH +: WIDTH])
        );
    end

    // Occupancy is kept in its own register, loaded with the popcount of the
    // valid bits the stages are about to take, so the output is a flop and
    // always equals the popcount of the stage valid flops.
    always_comb begin
        nextValid = stageValid;
        case (stageOp)
            STAGE_ADVANCE: nextValid = stageValidIn;
            STAGE_FLUSH:   nextValid = '0;
            default:       nextValid = stageValid;
        endcase
        occ_d = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occ_d = occ_d + OCC_W'(nextValid[k]);
        end
    end

    // Stall counter counts only true stalls (a flush on the same edge wins)
    // and sticks at all-ones instead of wrapping.
    always_comb begin
        stallCnt_d = stallCnt_q;
        if ((stageOp == STAGE_HOLD) && (stallCnt_q != {CNT_W{1'b1}})) begin
            stallCnt_d = stallCnt_q + CNT_W'(1);
        end
    end

    // Bookkeeping registers; the counter clears only on reset.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            occ_q      <= '0;
            stallCnt_q <= '0;
        end else begin
            occ_q      <= occ_d;
            stallCnt_q <= stallCnt_d;
        end
    end

    assign OutValid    = stageValid[DEPTH-1];
    assign OutData     = stageData[(DEPTH-1)*WIDTH +: WIDTH];
    assign Occupancy   = occ_q;
    assign StallCycles = stallCnt_q;

endmodule
